// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - mode-driven clear/count/readout sequencer for the histogram RAM
// Owns the single-port RAM: zero-fills it, bins hit rising edges per time bin, or streams it out.
module count_seq_ctrl #(
   parameter int ADDR_BITS  = 12,
   parameter int DATA_BITS  = 12,
   parameter int MEM_SIZE   = 64,
   parameter int BIN_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           mode,
   input  logic                 hit,
   input  logic                 read,
   input  logic                 out_ready,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_we,
   output logic                 mem_re,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic [DATA_BITS-1:0] dout,
   output logic [ADDR_BITS-1:0] dout_addr,
   output logic                 dout_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 mode_err
);

   localparam int CYC_W = (BIN_CYCLES > 1) ? $clog2(BIN_CYCLES) : 1;
   localparam logic [CYC_W-1:0]     CYC_LAST = CYC_W'(BIN_CYCLES - 1);
   localparam logic [ADDR_BITS-1:0] MEM_LAST = ADDR_BITS'(MEM_SIZE - 1);
   localparam logic [DATA_BITS-1:0] ACC_MAX  = '1;

   localparam logic [2:0] MODE_IDLE  = 3'b000;
   localparam logic [2:0] MODE_CLEAR = 3'b100;
   localparam logic [2:0] MODE_COUNT = 3'b001;
   localparam logic [2:0] MODE_READ  = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_COUNT, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_DONE
   } state_t;

   state_t               state_q;
   logic [2:0]           op_mode_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [CYC_W-1:0]     cyc_q;
   logic [DATA_BITS-1:0] acc_q;
   logic                 hit_q;
   logic [DATA_BITS-1:0] dout_q;
   logic [ADDR_BITS-1:0] dout_addr_q;
   logic                 dout_valid_q;
   logic                 mode_err_q;

   logic                 hit_rise;
   logic                 abort;
   logic                 bin_end;
   logic [DATA_BITS-1:0] acc_d;

   assign hit_rise = hit & ~hit_q;
   assign abort    = (mode != op_mode_q);
   assign bin_end  = (cyc_q == CYC_LAST);
   // A hit landing in the bin's last cycle (or the abort cycle) still counts into that bin.
   assign acc_d    = (acc_q == ACC_MAX) ? acc_q : acc_q + DATA_BITS'(hit_rise);

   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = addr_q;
         end
         S_COUNT: begin
            if (abort || bin_end) begin
               mem_we    = 1'b1;
               mem_addr  = addr_q;
               mem_wdata = acc_d;
            end
         end
         S_RD_REQ: begin
            if (!abort && read) begin
               mem_re   = 1'b1;
               mem_addr = addr_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_mode_q    <= '0;
         addr_q       <= '0;
         cyc_q        <= '0;
         acc_q        <= '0;
         hit_q        <= 1'b0;
         dout_q       <= '0;
         dout_addr_q  <= '0;
         dout_valid_q <= 1'b0;
         mode_err_q   <= 1'b0;
      end else begin
         hit_q <= hit;
         case (state_q)
            S_IDLE: begin
               op_mode_q <= mode;
               addr_q    <= '0;
               cyc_q     <= '0;
               acc_q     <= '0;
               case (mode)
                  MODE_CLEAR: state_q <= S_CLEAR;
                  MODE_COUNT: state_q <= S_COUNT;
                  MODE_READ:  state_q <= S_RD_REQ;
                  MODE_IDLE:  state_q <= S_IDLE;
                  default:    mode_err_q <= 1'b1;
               endcase
            end
            S_CLEAR: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (addr_q == MEM_LAST) begin
                  addr_q  <= '0;
                  state_q <= S_DONE;
               end else begin
                  addr_q <= addr_q + ADDR_BITS'(1);
               end
            end
            S_COUNT: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (bin_end) begin
                  acc_q <= '0;
                  cyc_q <= '0;
                  if (addr_q == MEM_LAST) begin
                     addr_q  <= '0;
                     state_q <= S_DONE;
                  end else begin
                     addr_q <= addr_q + ADDR_BITS'(1);
                  end
               end else begin
                  acc_q <= acc_d;
                  cyc_q <= cyc_q + CYC_W'(1);
               end
            end
            S_RD_REQ: begin
               if (abort) state_q <= S_IDLE;
               else if (read) state_q <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else begin
                  dout_q       <= mem_rdata;
                  dout_addr_q  <= addr_q;
                  dout_valid_q <= 1'b1;
                  state_q      <= S_RD_OUT;
               end
            end
            S_RD_OUT: begin
               if (abort) begin
                  dout_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (out_ready) begin
                  dout_valid_q <= 1'b0;
                  if (addr_q == MEM_LAST) begin
                     addr_q  <= '0;
                     state_q <= S_DONE;
                  end else begin
                     addr_q  <= addr_q + ADDR_BITS'(1);
                     state_q <= S_RD_REQ;
                  end
               end
            end
            S_DONE: begin
               if (mode == MODE_IDLE) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_addr  = dout_addr_q;
   assign dout_valid = dout_valid_q;
   assign mode_err   = mode_err_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = (state_q == S_DONE);

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Mode-driven sequencer for the counting system's MEM_SIZE x DATA_BITS histogram memory.
- Decodes the 3-bit mode word (000 idle, 100 clear, 001 data taking, 010 read).
- Owns the memory port: zero-fills the memory, bins hit pulses into time bins (one memory word per bin), or streams the memory out on a valid/ready interface.
- Sits between the top-level mode/hit/read controls and a single-port synchronous RAM with 1-cycle read latency.

Parameters:
ADDR_BITS, 12, memory address width; requires 2^ADDR_BITS >= MEM_SIZE
DATA_BITS, 12, counter/memory word width
MEM_SIZE, 64, number of bins/words used (addresses 0..MEM_SIZE-1)
BIN_CYCLES, 16, clock cycles per time bin in data taking (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
mode  in  3  operation select, level
hit  in  1  hit input, synchronous to clk; rising edges are counted
read  in  1  readout enable/pause, level
out_ready  in  1  downstream accepts dout when high
mem_rdata  in  DATA_BITS  RAM read data, valid 1 cycle after mem_re
mem_addr  out  ADDR_BITS  RAM address
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_wdata  out  DATA_BITS  RAM write data
dout  out  DATA_BITS  readout word
dout_addr  out  ADDR_BITS  address of dout
dout_valid  out  1  dout valid
busy  out  1  operation in progress
done  out  1  operation completed; held until mode==000
mode_err  out  1  sticky: unsupported mode seen in IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Asserting rst_n low mid-operation aborts immediately; no partial-bin write.
- States: IDLE, CLEAR, COUNT, RD_REQ, RD_WAIT, RD_OUT, DONE.
- IDLE transitions:
  - mode 100 -> CLEAR.
  - mode 001 -> COUNT.
  - mode 010 -> RD_REQ.
  - mode 000 stays IDLE.
  - Any other mode sets mode_err=1 (cleared only by reset) and stays IDLE.
- busy=1 in every state except IDLE and DONE.
- DONE: done=1; returns to IDLE the cycle after mode==000.
- Abort: in CLEAR/COUNT/RD_*, if mode differs from the mode that started the operation, go to IDLE next cycle.
  - COUNT abort first issues one write of the partial bin (one cycle), then goes to IDLE.
  - done is not asserted on abort.
- CLEAR:
  - One write per cycle: mem_we=1, mem_wdata=0, mem_addr=0,1,..,MEM_SIZE-1.
  - MEM_SIZE cycles total, then DONE.
- COUNT:
  - Hit detection: hit_rise = hit & ~hit_q. hit_q resets to 0 and is updated every cycle in all states. A hit held high for N cycles counts once.
  - acc (DATA_BITS) increments on hit_rise and saturates at 2^DATA_BITS-1.
  - cyc counts 0..BIN_CYCLES-1. On cyc==BIN_CYCLES-1:
    - mem_we=1, mem_addr=bin, mem_wdata = acc + hit_rise (saturated). A hit in the last cycle counts into the ending bin.
    - acc<=0, cyc<=0, bin<=bin+1.
  - After bin MEM_SIZE-1 is written -> DONE.
- Read:
  - RD_REQ: waits while read==0. When read==1, pulses mem_re with mem_addr=ptr -> RD_WAIT.
  - RD_WAIT (1 cycle): captures mem_rdata into dout, dout_addr=ptr, dout_valid=1 -> RD_OUT.
  - RD_OUT: dout/dout_addr/dout_valid held stable until out_ready==1. On the accepting cycle, dout_valid drops next cycle and ptr increments.
    - If ptr was MEM_SIZE-1 -> DONE; else -> RD_REQ.
  - Max throughput: 1 word per 3 cycles. Deasserting read pauses only at RD_REQ and never drops an issued word.
- mem_we and mem_re are never high together. mem_addr is 0 when both are low.
- Internal counters wrap only at the stated limits. No address ever reaches MEM_SIZE.

Test Plan:
- Clear: reset, mode=100 for 70 cycles -> mem_we high exactly 64 consecutive cycles, addr 0..63, wdata 0; done=1; done=0 and IDLE one cycle after mode=000.
- Data taking, BIN_CYCLES=16: 3 single-cycle hits in bin 0, none in bin 1, hit high 5 cycles in bin 2, hit in cycle 15 of bin 3 -> words 3,0,1,1 written at cycles 15,31,47,63; done after bin 63.
- Saturation, DATA_BITS=4, BIN_CYCLES=40: 18 hits in one bin -> written value 15.
- Readout with backpressure after preload mem[k]=k: mode=010, read=1, out_ready toggling 1/0 -> 64 words in order, dout stable while stalled, none lost; read low for 10 cycles mid-stream pauses without loss; done at end.
- Abort: mode 001 -> 000 at cycle 8 of bin 5 with 2 hits -> one write mem[5]=2, IDLE, done=0. Mode 011 in IDLE -> mode_err=1, sticky.
- rst_n low during RD_OUT -> all outputs 0 immediately. mode=010 after reset restarts from addr 0.
